// File: rtl/intc_pkg.sv
// intc_pkg: shared types and default sizes for the multi-source interrupt
// controller (intc_multi and intc_prio_enc).
//   intc_state_t  : dispatch FSM state (IDLE / SERVICE)
//   INTC_NUM_SRC  : default number of interrupt sources
//   INTC_DATA_W   : default payload width
package intc_pkg;

  localparam int INTC_NUM_SRC = 4;
  localparam int INTC_DATA_W  = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational fixed-priority encoder, index 0 highest.
// Ports:
//   eligible [NUM_SRC]  candidate request vector
//   valid               at least one bit of eligible is set
//   idx      [ID_W]     index of the lowest set bit (0 when none is set)
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NUM_SRC = INTC_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |eligible;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/intc_multi.sv
// intc_multi: NUM_SRC-source interrupt controller in front of the fetch/decode
// interrupt path. Each source has a pending latch, a captured payload word,
// a sticky overrun flag and an enable bit in a shared mask register. The
// lowest-indexed eligible source is dispatched with a one-cycle interrupt
// pulse; the controller then waits in SERVICE until an RTI/RSI retire pulse.
//
// Build option: define INTC_SYNC_EN to pass each irq_src bit through a
// 2-flop synchroniser ahead of edge detection (dispatch latency 2 -> 4).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   irq_src       raw interrupt requests, one per source
//   src_data      per-source payload, slice i = bits [i*DATA_W +: DATA_W]
//   hold          pipeline stall/flush; blocks dispatch while high
//   rti, rsi      handler retire pulses; either one ends SERVICE
//   mask_we       load mask register from mask_wdata
//   clr_overrun   clear all sticky overrun flags
//   interrupt     one-cycle dispatch pulse
//   irq_id        index of the dispatched source
//   irq_data      payload of the dispatched source (feeds RDI)
//   in_service    high while a handler is active
//   pending       pending latches (status)
//   overrun       sticky overrun flags
module intc_multi
  import intc_pkg::*;
#(
  parameter int                 NUM_SRC   = INTC_NUM_SRC,
  parameter int                 DATA_W    = INTC_DATA_W,
  parameter int                 ID_W      = $clog2(NUM_SRC),
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          irq_src,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic                        hold,
  input  logic                        rti,
  input  logic                        rsi,
  input  logic                        mask_we,
  input  logic [NUM_SRC-1:0]          mask_wdata,
  input  logic                        clr_overrun,
  output logic                        interrupt,
  output logic [ID_W-1:0]             irq_id,
  output logic [DATA_W-1:0]           irq_data,
  output logic                        in_service,
  output logic [NUM_SRC-1:0]          pending,
  output logic [NUM_SRC-1:0]          overrun
);

  intc_state_t                      state;
  logic [NUM_SRC-1:0]               mask;
  logic [NUM_SRC-1:0]               src_s;
  logic [NUM_SRC-1:0]               src_prev;
  logic [NUM_SRC-1:0]               evt;
  logic [NUM_SRC-1:0]               eligible;
  logic [NUM_SRC-1:0][DATA_W-1:0]   payload;
  logic                             win_vld;
  logic [ID_W-1:0]                  win_id;
  logic                             dispatch;

  // ---------------------------------------------------------------------------
  // Request conditioning
  // ---------------------------------------------------------------------------
`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif

  always_ff @(posedge clk) begin
    if (rst) src_prev <= '0;
    else     src_prev <= src_s;
  end

  // Edge sources fire on 0->1, level sources fire every cycle they are high.
  assign evt = (src_s & ~src_prev & EDGE_MASK) | (src_s & ~EDGE_MASK);

  // ---------------------------------------------------------------------------
  // Arbitration (uses the mask as it stands this cycle, so a mask write in the
  // dispatch cycle only affects later decisions)
  // ---------------------------------------------------------------------------
  assign eligible = pending & mask;

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .eligible (eligible),
    .valid    (win_vld),
    .idx      (win_id)
  );

  assign dispatch = (state == IDLE) && win_vld && !hold;

  // ---------------------------------------------------------------------------
  // Per-source pending / payload / overrun
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic              win_hit;
    logic              take;
    logic              ovr_set;
    logic              pend_r;
    logic              ovr_r;
    logic [DATA_W-1:0] pay_r;

    assign win_hit = dispatch && (win_id == ID_W'(i));
    // The slot is free either when nothing is pending or when the pending
    // request is being dispatched right now; a fresh event then reloads it.
    assign take    = evt[i] && (!pend_r || win_hit);
    // First event wins: a second edge on an occupied slot only flags overrun.
    assign ovr_set = evt[i] && EDGE_MASK[i] && pend_r && !win_hit;

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_r <= 1'b0;
        ovr_r  <= 1'b0;
        pay_r  <= '0;
      end else begin
        if (evt[i])       pend_r <= 1'b1;
        else if (win_hit) pend_r <= 1'b0;

        if (take) pay_r <= src_data[i*DATA_W +: DATA_W];

        if (ovr_set)          ovr_r <= 1'b1;
        else if (clr_overrun) ovr_r <= 1'b0;
      end
    end

    assign pending[i] = pend_r;
    assign overrun[i] = ovr_r;
    assign payload[i] = pay_r;
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '1;
      interrupt  <= 1'b0;
      irq_id     <= '0;
      irq_data   <= '0;
      in_service <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      if (mask_we) mask <= mask_wdata;

      case (state)
        IDLE: begin
          if (dispatch) begin
            interrupt  <= 1'b1;
            irq_id     <= win_id;
            irq_data   <= payload[win_id];
            in_service <= 1'b1;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          // rti and rsi together are a single return.
          if (rti || rsi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
